// File: rtl/aes128_inv_pkg.sv
// Shared types, tables and GF(2^8) helpers for the AES-128 inverse cipher core.
package aes128_inv_pkg;

    typedef enum logic [2:0] {IDLE, KEXP, ARK0, ROUND, DONE} state_e;

    // Byte n of each table sits at bits [2047-8n -: 8]
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul09(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gmul0b(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gmul0d(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gmul0e(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gmul0e(a0) ^ gmul0b(a1) ^ gmul0d(a2) ^ gmul09(a3),
                gmul09(a0) ^ gmul0e(a1) ^ gmul0b(a2) ^ gmul0d(a3),
                gmul0d(a0) ^ gmul09(a1) ^ gmul0e(a2) ^ gmul0b(a3),
                gmul0b(a0) ^ gmul0d(a1) ^ gmul09(a2) ^ gmul0e(a3)};
    endfunction

    // SubWord(RotWord(w)) as used by the key schedule
    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

endpackage

// File: rtl/aes128_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the last round.
module aes128_inv_round
    import aes128_inv_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         last,
    output logic [127:0] state_out
);

    logic [127:0] shifted;
    logic [127:0] keyed;
    logic [127:0] mixed;

    // Byte 4c+r is row r of column c; row r rotates right by r columns
    always_comb begin
        shifted = '0;
        keyed   = '0;
        mixed   = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[127 - 8*(4*c + r) -: 8] = state_in[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
            end
        end
        for (int i = 0; i < 16; i++) begin
            keyed[127 - 8*i -: 8] = inv_sbox(shifted[127 - 8*i -: 8]) ^ round_key[127 - 8*i -: 8];
        end
        for (int c = 0; c < 4; c++) begin
            mixed[127 - 32*c -: 32] = inv_mix_column(keyed[127 - 32*c -: 32]);
        end
        state_out = last ? keyed : mixed;
    end

endmodule

// File: rtl/aes128_inv_core.sv
// Iterative AES-128 decryptor, one round per clock, with forward key expansion
// followed by an on-the-fly reverse key schedule.
// Optional feature: define AES_INV_KEY_CACHE_EN to keep the last key and its
// round key 10 so a repeat key skips the expansion phase.
//
// state | meaning
// IDLE  | waiting for start; latches ct and key
// KEXP  | 10 cycles of forward expansion up to round key 10
// ARK0  | initial AddRoundKey with round key 10
// ROUND | 10 inverse rounds, round key stepped backwards each cycle
// DONE  | one-cycle done pulse with pt valid
module aes128_inv_core
    import aes128_inv_pkg::*;
#(
    parameter bit HOLD_OUTPUT = 1'b1
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] ct,
    input  logic [127:0] key,
    output logic         busy,
    output logic         done,
    output logic [127:0] pt
);

    function automatic logic [127:0] fwd_key(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] w4, w5, w6, w7;
        w4 = rk[127:96] ^ sub_rot_word(rk[31:0]) ^ {rc, 24'h0};
        w5 = rk[95:64] ^ w4;
        w6 = rk[63:32] ^ w5;
        w7 = rk[31:0]  ^ w6;
        return {w4, w5, w6, w7};
    endfunction

    function automatic logic [127:0] inv_key(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = rk[31:0]  ^ rk[63:32];
        w2 = rk[63:32] ^ rk[95:64];
        w1 = rk[95:64] ^ rk[127:96];
        w0 = rk[127:96] ^ sub_rot_word(w3) ^ {rc, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

    state_e       state_q, state_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] pt_q, pt_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] rk_prev;
    logic [127:0] round_out;
`ifdef AES_INV_KEY_CACHE_EN
    logic [127:0] key_q, key_d;
    logic [127:0] cache_key_q, cache_key_d;
    logic [127:0] cache_rk_q, cache_rk_d;
    logic         cache_vld_q, cache_vld_d;
    logic         cache_hit;

    assign cache_hit = cache_vld_q && (key == cache_key_q);
`endif

    // In ROUND, cnt_q is the round index r; rk_q holds rk_{r+1}
    assign rk_prev = inv_key(rk_q, rcon(cnt_q));

    aes128_inv_round u_round (
        .state_in  (st_q),
        .round_key (rk_prev),
        .last      (cnt_q == 4'd0),
        .state_out (round_out)
    );

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        rk_d    = rk_q;
        pt_d    = pt_q;
        cnt_d   = cnt_q;
`ifdef AES_INV_KEY_CACHE_EN
        key_d       = key_q;
        cache_key_d = cache_key_q;
        cache_rk_d  = cache_rk_q;
        cache_vld_d = cache_vld_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    st_d    = ct;
                    rk_d    = key;
                    cnt_d   = 4'd9;
                    state_d = KEXP;
`ifdef AES_INV_KEY_CACHE_EN
                    key_d = key;
                    if (cache_hit) begin
                        rk_d    = cache_rk_q;
                        state_d = ARK0;
                    end
`endif
                end
            end
            KEXP: begin
                rk_d = fwd_key(rk_q, rcon(4'd9 - cnt_q));
                if (cnt_q == 4'd0) begin
                    state_d = ARK0;
`ifdef AES_INV_KEY_CACHE_EN
                    cache_key_d = key_q;
                    cache_rk_d  = rk_d;
                    cache_vld_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ARK0: begin
                st_d    = st_q ^ rk_q;
                cnt_d   = 4'd9;
                state_d = ROUND;
            end
            ROUND: begin
                st_d = round_out;
                rk_d = rk_prev;
                if (cnt_q == 4'd0) begin
                    pt_d    = round_out;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            st_q    <= '0;
            rk_q    <= '0;
            pt_q    <= '0;
            cnt_q   <= '0;
`ifdef AES_INV_KEY_CACHE_EN
            key_q       <= '0;
            cache_key_q <= '0;
            cache_rk_q  <= '0;
            cache_vld_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            rk_q    <= rk_d;
            pt_q    <= pt_d;
            cnt_q   <= cnt_d;
`ifdef AES_INV_KEY_CACHE_EN
            key_q       <= key_d;
            cache_key_q <= cache_key_d;
            cache_rk_q  <= cache_rk_d;
            cache_vld_q <= cache_vld_d;
`endif
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign pt   = (HOLD_OUTPUT || state_q == DONE) ? pt_q : '0;

endmodule

// File: tb/tb_aes128_inv_core.sv
// Testbench for aes128_inv_core: FIPS/NIST vectors, handshake corner cases,
// mid-operation reset and a round trip against a bench-side AES encryptor.
module tb_aes128_inv_core;

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [127:0] ct = '0;
    logic [127:0] key = '0;
    logic         busy, done, busy0, done0;
    logic [127:0] pt, pt0;

    int checks = 0;
    int errors = 0;

    bit           cache_vld = 1'b0;
    logic [127:0] cache_key = '0;
    logic [7:0]   sb [256];

    always #5 clk = ~clk;

    aes128_inv_core #(.HOLD_OUTPUT(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .ct(ct), .key(key),
        .busy(busy), .done(done), .pt(pt)
    );

    aes128_inv_core #(.HOLD_OUTPUT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .ct(ct), .key(key),
        .busy(busy0), .done(done0), .pt(pt0)
    );

    task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Zero-hold instance: pt must be 0 outside the done cycle, result inside it
    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if (done0 !== done || (done0 ? (pt0 !== pt) : (pt0 !== '0))) begin
                errors++;
                $display("FAIL hold0_out: done0 %b pt0 %h expected done %b pt %h",
                         done0, pt0, done, done ? pt : 128'h0);
            end
        end
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse then affine map
    task automatic build_sbox();
        logic [7:0] inv, b;
        for (int i = 0; i < 256; i++) begin
            b = i[7:0];
            inv = 8'h00;
            if (b != 8'h00) begin
                inv = 8'h01;
                for (int j = 0; j < 254; j++) inv = gmul(inv, b);
            end
            sb[i] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                    {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] p, input logic [127:0] k);
        logic [127:0] s, t;
        logic [31:0]  w, tmp;
        logic [7:0]   rc, a0, a1, a2, a3;
        rc = 8'h01;
        s = p ^ k;
        for (int r = 1; r <= 10; r++) begin
            w = k[31:0];
            tmp = {sb[w[23:16]], sb[w[15:8]], sb[w[7:0]], sb[w[31:24]]} ^ {rc, 24'h0};
            k[127:96] = k[127:96] ^ tmp;
            k[95:64]  = k[95:64] ^ k[127:96];
            k[63:32]  = k[63:32] ^ k[95:64];
            k[31:0]   = k[31:0] ^ k[63:32];
            rc = gmul(rc, 8'h02);
            for (int i = 0; i < 16; i++) t[127 - 8*i -: 8] = sb[s[127 - 8*i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[127 - 8*(4*c + row) -: 8] = t[127 - 8*(4*((c + row) % 4) + row) -: 8];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    {a0, a1, a2, a3} = s[127 - 32*c -: 32];
                    s[127 - 32*c -: 32] = {gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3,
                                           a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3,
                                           a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03),
                                           gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02)};
                end
            end
            s = s ^ k;
        end
        return s;
    endfunction

    // Issue one request from a negedge; window of 30 cycles after acceptance.
    // pulse_at: cycle offset at which start is raised again with other ct/key (0 = never).
    task automatic run_req(input string name, input logic [127:0] c, input logic [127:0] k,
                           input logic [127:0] exp_pt, input int pulse_at);
        int exp_lat, done_at, n_done;
        bit busy_ok;
        logic [127:0] pt_done, pt_after;
        exp_lat = 22;
`ifdef AES_INV_KEY_CACHE_EN
        if (cache_vld && k == cache_key) exp_lat = 12;
`endif
        done_at = 0;
        n_done = 0;
        busy_ok = (busy === 1'b0);
        pt_done = '0;
        pt_after = '0;
        ct = c;
        key = k;
        start = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            start = (i == pulse_at);
            if (i == pulse_at) begin
                ct = ~c;
                key = ~k;
            end
            if (busy !== (i <= exp_lat)) busy_ok = 1'b0;
            if (done === 1'b1) begin
                n_done++;
                if (done_at == 0) begin
                    done_at = i;
                    pt_done = pt;
                end
            end
            if (i == exp_lat + 1) pt_after = pt;
        end
        start = 1'b0;
        check_int({name, "_latency"}, done_at, exp_lat);
        check_int({name, "_done_count"}, n_done, 1);
        check_int({name, "_busy_window"}, int'(busy_ok), 1);
        check128({name, "_pt"}, pt_done, exp_pt);
        check128({name, "_pt_hold"}, pt_after, exp_pt);
        cache_vld = 1'b1;
        cache_key = k;
    endtask

    initial begin
        vec_t vecs [5];
        logic [127:0] k, p;
        int n;

        build_sbox();

        vecs[0] = '{key: 128'h00000000000000000000000000000000,
                    ct:  128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                    pt:  128'h00000000000000000000000000000000};
        vecs[1] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                    ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                    pt:  128'h00112233445566778899aabbccddeeff};
        vecs[2] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    ct:  128'h3925841d02dc09fbdc118597196a0b32,
                    pt:  128'h3243f6a8885a308d313198a2e0370734};
        vecs[3] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    ct:  128'h3ad77bb40d7a3660a89ecaf32466ef97,
                    pt:  128'h6bc1bee22e409f96e93d7e117393172a};
        vecs[4] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    ct:  128'hf5d3d58503b9699de785895a96fdbaaf,
                    pt:  128'hae2d8a571e03ac9c9eb76fac45af8e51};

        repeat (2) @(negedge clk);
        check_int("reset_busy", int'(busy), 0);
        check_int("reset_done", int'(done), 0);
        check128("reset_pt", pt, '0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_req($sformatf("vec%0d", i), vecs[i].ct, vecs[i].key, vecs[i].pt, 0);
        end

        // Second start at T+5 with different ct/key must be ignored
        run_req("restart_t5", vecs[1].ct, vecs[1].key, vecs[1].pt, 5);

        // start raised during the done cycle must not be accepted
        k = vecs[2].key;
        run_req("start_in_done", vecs[2].ct, k,
                vecs[2].pt, (cache_vld && k == cache_key) ? 12 : 22);

        // Reset at T+8 of a request aborts it immediately
        ct = vecs[1].ct;
        key = vecs[1].key;
        start = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b0;
        #1;
        check_int("abort_busy", int'(busy), 0);
        check_int("abort_done", int'(done), 0);
        check128("abort_pt", pt, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        cache_vld = 1'b0;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
        check_int("abort_no_done", n, 0);
        run_req("after_abort", vecs[1].ct, vecs[1].key, vecs[1].pt, 0);

        // Same key twice in a row, then a different key
        run_req("same_key", vecs[1].ct, vecs[1].key, vecs[1].pt, 0);
        run_req("other_key", vecs[0].ct, vecs[0].key, vecs[0].pt, 0);

        // Round trip through the bench encryptor
        for (int i = 0; i < 200; i++) begin
            if (i % 10 != 9) k = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom, $urandom, $urandom};
            run_req($sformatf("rt%0d", i), aes_enc(p, k), k, p, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
